// File: rtl/box_overlay_pkg.sv
// box_overlay_pkg: shared state, coordinate and pixel types plus the edge clamp helper. Rev 1.0
`default_nettype none

package box_overlay_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef logic [11:0] coord_t;
  typedef logic [23:0] rgb_t;

  // Out-of-range low edges snap to 0 (catches 0-1 wrapping to 4095); high edges snap to limit-1.
  function automatic coord_t clamp_coord(input coord_t val, input coord_t limit, input logic high_edge);
    coord_t res;
    res = val;
    if (val >= limit) begin
      res = high_edge ? coord_t'(limit - 12'd1) : '0;
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/box_hold_fsm.sv
// box_hold_fsm: per-frame box capture, clamp, validity and hold/coast FSM. Rev 1.0
// Optional BOX_OVERLAY_CENTER_MARK_EN adds the captured box centre outputs.
`default_nettype none

module box_hold_fsm
  import box_overlay_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int HOLD_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lcd_vs,
  input  logic [11:0] hcount_l,
  input  logic [11:0] hcount_r,
  input  logic [11:0] vcount_l,
  input  logic [11:0] vcount_r,
  output logic [11:0] box_l,
  output logic [11:0] box_r,
  output logic [11:0] box_t,
  output logic [11:0] box_b,
  output logic        box_valid
`ifdef BOX_OVERLAY_CENTER_MARK_EN
  ,
  output logic [11:0] box_cx,
  output logic [11:0] box_cy
`endif
);

  localparam coord_t H_LIM      = coord_t'(H_ACTIVE);
  localparam coord_t V_LIM      = coord_t'(V_ACTIVE);
  localparam logic [7:0] HOLD_N = 8'(HOLD_FRAMES);

  logic   vs_d1, vs_d2, cap;
  state_t state, next_state;
  logic [7:0] hold_cnt, next_cnt;
  logic   load, clear;
  coord_t cl_l, cl_r, cl_t, cl_b;
  logic   in_valid;

  assign cl_l     = clamp_coord(hcount_l, H_LIM, 1'b0);
  assign cl_r     = clamp_coord(hcount_r, H_LIM, 1'b1);
  assign cl_t     = clamp_coord(vcount_l, V_LIM, 1'b0);
  assign cl_b     = clamp_coord(vcount_r, V_LIM, 1'b1);
  assign in_valid = (cl_l < cl_r) && (cl_t < cl_b);

  always_comb begin
    next_state = state;
    next_cnt   = hold_cnt;
    load       = 1'b0;
    clear      = 1'b0;
    if (cap) begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            load = 1'b1; next_cnt = HOLD_N; next_state = TRACK;
          end
        end
        TRACK: begin
          if (in_valid) begin
            load = 1'b1; next_cnt = HOLD_N;
          end else begin
            next_cnt = hold_cnt - 8'd1; next_state = HOLD;
          end
        end
        HOLD: begin
          if (in_valid) begin
            load = 1'b1; next_cnt = HOLD_N; next_state = TRACK;
          end else if (hold_cnt == 8'd1) begin
            clear = 1'b1; next_cnt = 8'd0; next_state = IDLE;
          end else begin
            next_cnt = hold_cnt - 8'd1;
          end
        end
        default: begin
          clear = 1'b1; next_cnt = 8'd0; next_state = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_d1     <= 1'b0;
      vs_d2     <= 1'b0;
      cap       <= 1'b0;
      state     <= IDLE;
      hold_cnt  <= 8'd0;
      box_valid <= 1'b0;
      box_l     <= '0;
      box_r     <= '0;
      box_t     <= '0;
      box_b     <= '0;
    end else begin
      vs_d1     <= lcd_vs;
      vs_d2     <= vs_d1;
      cap       <= vs_d1 & ~vs_d2;
      state     <= next_state;
      hold_cnt  <= next_cnt;
      box_valid <= (next_state != IDLE);
      if (load) begin
        box_l <= cl_l; box_r <= cl_r; box_t <= cl_t; box_b <= cl_b;
      end else if (clear) begin
        box_l <= '0; box_r <= '0; box_t <= '0; box_b <= '0;
      end
    end
  end

`ifdef BOX_OVERLAY_CENTER_MARK_EN
  logic [12:0] sum_h, sum_v;
  assign sum_h = {1'b0, cl_l} + {1'b0, cl_r};
  assign sum_v = {1'b0, cl_t} + {1'b0, cl_b};

  // Centre only moves on a successful load, so it is held through HOLD and IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      box_cx <= '0;
      box_cy <= '0;
    end else if (load) begin
      box_cx <= sum_h[12:1];
      box_cy <= sum_v[12:1];
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/box_overlay.sv
// box_overlay: 2-stage pipeline drawing the tracked bounding box onto the LCD stream. Rev 1.0
// Optional BOX_OVERLAY_CENTER_MARK_EN adds a centre cross and box_cx/box_cy ports.
`default_nettype none

module box_overlay
  import box_overlay_pkg::*;
#(
  parameter int          H_ACTIVE    = 640,
  parameter int          V_ACTIVE    = 480,
  parameter int          LINE_W      = 2,
  parameter logic [23:0] BOX_COLOR   = 24'hFF0000,
  parameter int          HOLD_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lcd_vs,
  input  logic        lcd_hs,
  input  logic        lcd_de,
  input  logic [11:0] hcount,
  input  logic [11:0] vcount,
  input  logic [23:0] lcd_data,
  input  logic [11:0] hcount_l,
  input  logic [11:0] hcount_r,
  input  logic [11:0] vcount_l,
  input  logic [11:0] vcount_r,
  output logic        lcd_vs_o,
  output logic        lcd_hs_o,
  output logic        lcd_de_o,
  output logic [23:0] lcd_data_o,
  output logic        box_valid
`ifdef BOX_OVERLAY_CENTER_MARK_EN
  ,
  output logic [11:0] box_cx,
  output logic [11:0] box_cy
`endif
);

  localparam logic [12:0] LW = 13'(LINE_W);

  coord_t box_l, box_r, box_t, box_b;

  box_hold_fsm #(
    .H_ACTIVE   (H_ACTIVE),
    .V_ACTIVE   (V_ACTIVE),
    .HOLD_FRAMES(HOLD_FRAMES)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .lcd_vs   (lcd_vs),
    .hcount_l (hcount_l),
    .hcount_r (hcount_r),
    .vcount_l (vcount_l),
    .vcount_r (vcount_r),
    .box_l    (box_l),
    .box_r    (box_r),
    .box_t    (box_t),
    .box_b    (box_b),
    .box_valid(box_valid)
`ifdef BOX_OVERLAY_CENTER_MARK_EN
    ,
    .box_cx   (box_cx),
    .box_cy   (box_cy)
`endif
  );

  // 13-bit compares so edge+LINE_W never wraps near 4095.
  logic [12:0] h13, v13, l13, r13, t13, b13;
  logic        in_box, on_edge, draw;

  assign h13 = {1'b0, hcount};
  assign v13 = {1'b0, vcount};
  assign l13 = {1'b0, box_l};
  assign r13 = {1'b0, box_r};
  assign t13 = {1'b0, box_t};
  assign b13 = {1'b0, box_b};

  assign in_box  = lcd_de && box_valid && (h13 >= l13) && (h13 <= r13) && (v13 >= t13) && (v13 <= b13);
  assign on_edge = (h13 < l13 + LW) || (h13 + LW > r13) || (v13 < t13 + LW) || (v13 + LW > b13);

`ifdef BOX_OVERLAY_CENTER_MARK_EN
  logic [12:0] cx13, cy13;
  logic        in_area, cross;
  assign cx13    = {1'b0, box_cx};
  assign cy13    = {1'b0, box_cy};
  assign in_area = (h13 < 13'(H_ACTIVE)) && (v13 < 13'(V_ACTIVE));
  assign cross   = lcd_de && box_valid && in_area &&
                   (((v13 == cy13) && (h13 + 13'd4 >= cx13) && (h13 <= cx13 + 13'd4)) ||
                    ((h13 == cx13) && (v13 + 13'd4 >= cy13) && (v13 <= cy13 + 13'd4)));
  assign draw    = (in_box && on_edge) || cross;
`else
  assign draw    = in_box && on_edge;
`endif

  logic        vs_q, hs_q, de_q, draw_q;
  logic [23:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q       <= 1'b0;
      hs_q       <= 1'b0;
      de_q       <= 1'b0;
      draw_q     <= 1'b0;
      data_q     <= '0;
      lcd_vs_o   <= 1'b0;
      lcd_hs_o   <= 1'b0;
      lcd_de_o   <= 1'b0;
      lcd_data_o <= '0;
    end else begin
      vs_q       <= lcd_vs;
      hs_q       <= lcd_hs;
      de_q       <= lcd_de;
      draw_q     <= draw;
      data_q     <= lcd_data;
      lcd_vs_o   <= vs_q;
      lcd_hs_o   <= hs_q;
      lcd_de_o   <= de_q;
      lcd_data_o <= draw_q ? BOX_COLOR : data_q;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_box_overlay.sv
// tb_box_overlay: directed, table-driven checks of box_overlay (HOLD_FRAMES=3). Rev 1.0
`default_nettype none

module tb_box_overlay;

  localparam logic [23:0] COLOR = 24'hFF0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lcd_vs = 1'b0, lcd_hs = 1'b0, lcd_de = 1'b0;
  logic [11:0] hcount = '0, vcount = '0;
  logic [23:0] lcd_data = '0;
  logic [11:0] hcount_l = '0, hcount_r = '0, vcount_l = '0, vcount_r = '0;
  logic        lcd_vs_o, lcd_hs_o, lcd_de_o, box_valid;
  logic [23:0] lcd_data_o;
`ifdef BOX_OVERLAY_CENTER_MARK_EN
  logic [11:0] box_cx, box_cy;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  box_overlay #(
    .H_ACTIVE(640), .V_ACTIVE(480), .LINE_W(2), .BOX_COLOR(COLOR), .HOLD_FRAMES(3)
  ) dut (
    .clk(clk), .rst(rst),
    .lcd_vs(lcd_vs), .lcd_hs(lcd_hs), .lcd_de(lcd_de),
    .hcount(hcount), .vcount(vcount), .lcd_data(lcd_data),
    .hcount_l(hcount_l), .hcount_r(hcount_r), .vcount_l(vcount_l), .vcount_r(vcount_r),
    .lcd_vs_o(lcd_vs_o), .lcd_hs_o(lcd_hs_o), .lcd_de_o(lcd_de_o),
    .lcd_data_o(lcd_data_o), .box_valid(box_valid)
`ifdef BOX_OVERLAY_CENTER_MARK_EN
    , .box_cx(box_cx), .box_cy(box_cy)
`endif
  );

  typedef struct {
    logic [11:0] h;
    logic [11:0] v;
    logic [23:0] din;
    logic [23:0] exp;
    string       name;
  } vec_t;

  vec_t basic_v[7];
  vec_t clamp_v[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One pixel in, sampled one and two cycles later.
  task automatic pix(input logic [11:0] h, input logic [11:0] v, input logic [23:0] d,
                     output logic [23:0] dout, output logic de_early, output logic de_now);
    @(negedge clk);
    lcd_de = 1'b1; hcount = h; vcount = v; lcd_data = d;
    @(negedge clk);
    lcd_de = 1'b0; lcd_data = '0;
    de_early = lcd_de_o;
    @(negedge clk);
    dout = lcd_data_o;
    de_now = lcd_de_o;
  endtask

  task automatic check_pix(input string name, input logic [11:0] h, input logic [11:0] v,
                           input logic [23:0] d, input logic [23:0] exp);
    logic [23:0] dout;
    logic e1, e2;
    pix(h, v, d, dout, e1, e2);
    check(name, {8'd0, dout}, {8'd0, exp});
  endtask

  task automatic capture(input logic [11:0] l, input logic [11:0] r,
                         input logic [11:0] t, input logic [11:0] b);
    @(negedge clk);
    hcount_l = l; hcount_r = r; vcount_l = t; vcount_r = b;
    lcd_vs = 1'b1;
    @(negedge clk);
    check("vs_o_lat1", {31'd0, lcd_vs_o}, 32'd0);
    @(negedge clk);
    check("vs_o_lat2", {31'd0, lcd_vs_o}, 32'd1);
    @(negedge clk);
    lcd_vs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] dout;
    logic e1, e2;

    basic_v[0] = '{12'd100, 12'd50,  24'h123456, COLOR,       "basic_100_50"};
    basic_v[1] = '{12'd101, 12'd120, 24'h223344, COLOR,       "basic_101_120"};
    basic_v[2] = '{12'd199, 12'd150, 24'h334455, COLOR,       "basic_199_150"};
    basic_v[3] = '{12'd102, 12'd120, 24'h445566, 24'h445566,  "basic_102_120"};
    basic_v[4] = '{12'd150, 12'd100, 24'h556677, 24'h556677,  "basic_150_100"};
    basic_v[5] = '{12'd200, 12'd100, 24'h667788, COLOR,       "basic_200_100"};
    basic_v[6] = '{12'd99,  12'd100, 24'h778899, 24'h778899,  "basic_99_outside"};

    clamp_v[0] = '{12'd0,   12'd0,   24'h0A0B0C, COLOR,       "clamp_0_0"};
    clamp_v[1] = '{12'd639, 12'd479, 24'h0B0C0D, COLOR,       "clamp_639_479"};
    clamp_v[2] = '{12'd1,   12'd240, 24'h0C0D0E, COLOR,       "clamp_1_240"};
    clamp_v[3] = '{12'd2,   12'd240, 24'h0D0E0F, 24'h0D0E0F,  "clamp_2_240"};
    clamp_v[4] = '{12'd638, 12'd240, 24'h0E0F10, COLOR,       "clamp_638_240"};
    clamp_v[5] = '{12'd637, 12'd240, 24'h0F1011, 24'h0F1011,  "clamp_637_240"};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data_o", {8'd0, lcd_data_o}, 32'd0);
    check("rst_syncs", {29'd0, lcd_vs_o, lcd_hs_o, lcd_de_o}, 32'd0);
    check("rst_box_valid", {31'd0, box_valid}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // No box before any capture: pass-through
    check_pix("idle_passthru", 12'd100, 12'd50, 24'hABCDEF, 24'hABCDEF);

    // hsync latency
    @(negedge clk); lcd_hs = 1'b1;
    @(negedge clk); lcd_hs = 1'b0;
    check("hs_o_lat1", {31'd0, lcd_hs_o}, 32'd0);
    @(negedge clk);
    check("hs_o_lat2", {31'd0, lcd_hs_o}, 32'd1);

    // Basic draw
    capture(12'd100, 12'd200, 12'd50, 12'd150);
    check("basic_box_valid", {31'd0, box_valid}, 32'd1);
    pix(basic_v[0].h, basic_v[0].v, basic_v[0].din, dout, e1, e2);
    check("latency_de_cycle1", {31'd0, e1}, 32'd0);
    check("latency_de_cycle2", {31'd0, e2}, 32'd1);
    check(basic_v[0].name, {8'd0, dout}, {8'd0, basic_v[0].exp});
    for (int i = 1; i < 7; i++) begin
      check_pix(basic_v[i].name, basic_v[i].h, basic_v[i].v, basic_v[i].din, basic_v[i].exp);
    end
`ifdef BOX_OVERLAY_CENTER_MARK_EN
    check("center_cx", {20'd0, box_cx}, 32'd150);
    check("center_cy", {20'd0, box_cy}, 32'd100);
    check_pix("cross_146_100", 12'd146, 12'd100, 24'h010203, COLOR);
    check_pix("cross_150_104", 12'd150, 12'd104, 24'h010203, COLOR);
    check_pix("cross_145_100", 12'd145, 12'd100, 24'h010203, 24'h010203);
`endif

    // Clamp
    capture(12'd4095, 12'd700, 12'd4095, 12'd500);
    check("clamp_box_valid", {31'd0, box_valid}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      check_pix(clamp_v[i].name, clamp_v[i].h, clamp_v[i].v, clamp_v[i].din, clamp_v[i].exp);
    end

    // Hold expiry (HOLD_FRAMES=3)
    capture(12'd0, 12'd0, 12'd0, 12'd0);
    check("hold1_valid", {31'd0, box_valid}, 32'd1);
    check_pix("hold1_pix", 12'd0, 12'd0, 24'h111111, COLOR);
    capture(12'd0, 12'd0, 12'd0, 12'd0);
    check("hold2_valid", {31'd0, box_valid}, 32'd1);
    check_pix("hold2_pix", 12'd639, 12'd479, 24'h111111, COLOR);
    capture(12'd0, 12'd0, 12'd0, 12'd0);
    check("hold3_valid", {31'd0, box_valid}, 32'd0);
    check_pix("expired_pix", 12'd0, 12'd0, 24'h222222, 24'h222222);

    // Recovery in HOLD
    capture(12'd100, 12'd200, 12'd50, 12'd150);
    capture(12'd0, 12'd0, 12'd0, 12'd0);
    check("rec_hold_valid", {31'd0, box_valid}, 32'd1);
    capture(12'd300, 12'd400, 12'd200, 12'd300);
    check_pix("rec_new_box", 12'd300, 12'd200, 24'h333333, COLOR);
    check_pix("rec_old_box_gone", 12'd100, 12'd50, 24'h333333, 24'h333333);
    capture(12'd0, 12'd0, 12'd0, 12'd0);
    capture(12'd0, 12'd0, 12'd0, 12'd0);
    check("rec_cnt_reloaded", {31'd0, box_valid}, 32'd1);
    check_pix("rec_still_drawn", 12'd400, 12'd300, 24'h444444, COLOR);
    capture(12'd0, 12'd0, 12'd0, 12'd0);
    check("rec_expired", {31'd0, box_valid}, 32'd0);

    // Mid-frame reset
    capture(12'd100, 12'd200, 12'd50, 12'd150);
    check_pix("pre_rst_draw", 12'd100, 12'd50, 24'h555555, COLOR);
    @(negedge clk);
    lcd_de = 1'b1; hcount = 12'd100; vcount = 12'd50; lcd_data = 24'h5A5A5A; lcd_hs = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("midrst_zero", {6'd0, lcd_vs_o, lcd_hs_o, lcd_de_o, box_valid, lcd_data_o}, 32'd0);
      if (i == 3) rst = 1'b0;
    end
    @(negedge clk);
    check("midrst_resume", {7'd0, lcd_de_o, lcd_data_o}, {7'd0, 1'b1, 24'h5A5A5A});
    lcd_de = 1'b0; lcd_hs = 1'b0; lcd_data = '0;
    repeat (2) @(negedge clk);
    check_pix("midrst_no_box", 12'd100, 12'd50, 24'h666666, 24'h666666);
    capture(12'd100, 12'd200, 12'd50, 12'd150);
    check_pix("midrst_redraw", 12'd100, 12'd50, 24'h777777, COLOR);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
